// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller.
// Owns the PC, runs req/ack fetches against instruction memory, and arbitrates
// branch-over-jump redirects. A one-entry skid register absorbs decode stalls.
// Also handles halt/resume.
// Optional feature macro: PC_ALIGN_CHECK_EN (rejects misaligned redirects and
// pulses align_fault); without it, redirect targets are forced word-aligned.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hlt,
  input  logic        resume,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic        jmp_taken,
  input  logic [31:0] jmp_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        halted,
  output logic        align_fault
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SKID, ST_HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_inst;
  logic        r_squash_pend;
  logic        r_halt_pend;
  logic        r_halted;
  logic        r_align_fault;

  logic        w_redir;
  logic [31:0] w_target_raw;
  logic [31:0] w_target;
  logic        w_misalign;
  logic        w_redir_ok;
  logic        w_halt_now;
  logic [31:0] w_pc_inc;

  // Redirect target selection: branch (execute) wins over jump (decode).
  always_comb begin
    w_redir      = br_taken | jmp_taken;
    w_target_raw = br_taken ? br_pc : jmp_pc;
`ifdef PC_ALIGN_CHECK_EN
    w_misalign   = w_redir && (w_target_raw[1:0] != 2'b00);
    w_target     = w_target_raw;
`else
    w_misalign   = 1'b0;
    w_target     = w_target_raw & ~32'h0000_0003;
`endif
    w_redir_ok   = w_redir & ~w_misalign;
    w_pc_inc     = r_pc + 32'd4;
    // In REQ a halt must wait for the outstanding ack, which is then dropped.
    if (r_state == ST_REQ) w_halt_now = (hlt | r_halt_pend) & imem_ack;
    else                   w_halt_now = hlt;
  end

  // Fetch FSM: PC sequencing, squash tracking, skid handling, halt/resume.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_pc       <= '0;
      r_if_inst     <= '0;
      r_skid_pc     <= '0;
      r_skid_inst   <= '0;
      r_squash_pend <= 1'b0;
      r_halt_pend   <= 1'b0;
      r_halted      <= 1'b0;
      r_align_fault <= 1'b0;
    end else begin
      r_align_fault <= 1'b0;
      if (r_state == ST_HALT) begin
        if (resume && !hlt) begin
          r_state  <= ST_REQ;
          r_halted <= 1'b0;
        end
      end else if (w_halt_now) begin
        r_state       <= ST_HALT;
        r_pc          <= RESET_PC;
        r_if_valid    <= 1'b0;
        r_skid_pc     <= '0;
        r_skid_inst   <= '0;
        r_squash_pend <= 1'b0;
        r_halt_pend   <= 1'b0;
        r_halted      <= 1'b1;
      end else if (r_state == ST_REQ && (hlt || r_halt_pend)) begin
        // Halt armed, ack not yet seen: keep req up, only let decode drain.
        r_halt_pend <= 1'b1;
        if (r_if_valid && !stall) r_if_valid <= 1'b0;
      end else begin
        r_align_fault <= w_misalign;
        if (w_redir_ok) begin
          r_pc          <= w_target;
          r_if_valid    <= 1'b0;
          r_skid_pc     <= '0;
          r_skid_inst   <= '0;
          // Ack in the same cycle is discarded here, so nothing to squash later.
          r_squash_pend <= (r_state == ST_REQ) && !imem_ack;
          r_state       <= ST_REQ;
        end else begin
          case (r_state)
            ST_IDLE: r_state <= ST_REQ;
            ST_REQ: begin
              if (imem_ack && r_squash_pend) begin
                r_squash_pend <= 1'b0;
                if (r_if_valid && !stall) r_if_valid <= 1'b0;
              end else if (imem_ack && (!r_if_valid || !stall)) begin
                r_if_inst  <= imem_rdata;
                r_if_pc    <= r_pc;
                r_if_valid <= 1'b1;
                r_pc       <= w_pc_inc;
              end else if (imem_ack) begin
                r_skid_inst <= imem_rdata;
                r_skid_pc   <= r_pc;
                r_pc        <= w_pc_inc;
                r_state     <= ST_SKID;
              end else if (r_if_valid && !stall) begin
                r_if_valid <= 1'b0;
              end
            end
            ST_SKID: begin
              if (!stall) begin
                r_if_inst   <= r_skid_inst;
                r_if_pc     <= r_skid_pc;
                r_if_valid  <= 1'b1;
                r_skid_pc   <= '0;
                r_skid_inst <= '0;
                r_state     <= ST_REQ;
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign imem_req    = (r_state == ST_REQ);
  assign imem_addr   = r_pc;
  assign if_valid    = r_if_valid;
  assign if_pc       = r_if_pc;
  assign if_inst     = r_if_inst;
  assign halted      = r_halted;
  assign align_fault = r_align_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: per-cycle vector table plus a
// hand-written misaligned-redirect sequence. Memory data is ~address.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, hlt, resume, stall, br_taken, jmp_taken, imem_ack;
  logic [31:0] br_pc, jmp_pc, imem_rdata;
  logic        imem_req, if_valid, halted, align_fault;
  logic [31:0] imem_addr, if_pc, if_inst;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = ~imem_addr;

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .hlt(hlt), .resume(resume), .stall(stall),
    .br_taken(br_taken), .br_pc(br_pc), .jmp_taken(jmp_taken), .jmp_pc(jmp_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .halted(halted), .align_fault(align_fault)
  );

  typedef struct {
    logic        rst, hlt, res, stall, ack, br;
    logic [31:0] brpc;
    logic        jmp;
    logic [31:0] jmppc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic        e_halt;
    logic        e_clr;
  } vec_t;

  function automatic vec_t V(input logic r, input logic h, input logic rs,
                             input logic s, input logic a, input logic b,
                             input logic [31:0] bp, input logic j,
                             input logic [31:0] jp, input logic eq,
                             input logic [31:0] ea, input logic ev,
                             input logic [31:0] ep, input logic eh);
    vec_t t;
    t.rst = r; t.hlt = h; t.res = rs; t.stall = s; t.ack = a; t.br = b;
    t.brpc = bp; t.jmp = j; t.jmppc = jp; t.e_req = eq; t.e_addr = ea;
    t.e_v = ev; t.e_pc = ep; t.e_halt = eh; t.e_clr = 1'b0;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; hlt = t.hlt; resume = t.res; stall = t.stall;
    imem_ack = t.ack; br_taken = t.br; br_pc = t.brpc;
    jmp_taken = t.jmp; jmp_pc = t.jmppc;
  endtask

  vec_t tbl [41];
  vec_t idle;

  initial begin
    // rst hlt res stl ack br brpc jmp jmppc | req addr v pc halted
    tbl[0]  = V(1,0,0,0,0, 0,0,0,0,            0,32'h0,0,32'h0,0);
    tbl[1]  = V(0,0,0,0,0, 0,0,0,0,            0,32'h0,0,32'h0,0);
    tbl[2]  = V(0,0,0,0,1, 0,0,0,0,            1,32'h0,0,32'h0,0);
    tbl[3]  = V(0,0,0,0,1, 0,0,0,0,            1,32'h4,1,32'h0,0);
    tbl[4]  = V(0,0,0,0,1, 0,0,0,0,            1,32'h8,1,32'h4,0);
    tbl[5]  = V(0,0,0,0,1, 0,0,0,0,            1,32'hC,1,32'h8,0);
    tbl[6]  = V(0,0,0,0,0, 0,0,0,0,            1,32'h10,1,32'hC,0);
    tbl[7]  = V(0,0,0,0,1, 0,0,0,0,            1,32'h10,0,32'h0,0);
    tbl[8]  = V(0,0,0,1,0, 0,0,0,0,            1,32'h14,1,32'h10,0);
    tbl[9]  = V(0,0,0,1,1, 0,0,0,0,            1,32'h14,1,32'h10,0);
    tbl[10] = V(0,0,0,1,0, 0,0,0,0,            0,32'h18,1,32'h10,0);
    tbl[11] = V(0,0,0,0,0, 0,0,0,0,            0,32'h18,1,32'h10,0);
    tbl[12] = V(0,0,0,0,0, 0,0,0,0,            1,32'h18,1,32'h14,0);
    tbl[13] = V(0,0,0,0,1, 0,0,0,0,            1,32'h18,0,32'h0,0);
    tbl[14] = V(0,0,0,0,0, 0,0,0,0,            1,32'h1C,1,32'h18,0);
    tbl[15] = V(0,0,0,0,0, 1,32'h100,1,32'h200, 1,32'h1C,0,32'h0,0);
    tbl[16] = V(0,0,0,0,1, 0,0,0,0,            1,32'h100,0,32'h0,0);
    tbl[17] = V(0,0,0,0,0, 0,0,0,0,            1,32'h100,0,32'h0,0);
    tbl[18] = V(0,0,0,0,1, 0,0,0,0,            1,32'h100,0,32'h0,0);
    tbl[19] = V(0,0,0,0,0, 0,0,0,0,            1,32'h104,1,32'h100,0);
    tbl[20] = V(0,0,0,0,1, 0,0,1,32'h200,      1,32'h104,0,32'h0,0);
    tbl[21] = V(0,0,0,0,1, 0,0,0,0,            1,32'h200,0,32'h0,0);
    tbl[22] = V(0,0,0,0,0, 0,0,0,0,            1,32'h204,1,32'h200,0);
    tbl[23] = V(0,1,0,0,0, 0,0,0,0,            1,32'h204,0,32'h0,0);
    tbl[24] = V(0,1,0,0,0, 0,0,0,0,            1,32'h204,0,32'h0,0);
    tbl[25] = V(0,1,0,0,0, 0,0,0,0,            1,32'h204,0,32'h0,0);
    tbl[26] = V(0,1,0,0,1, 0,0,0,0,            1,32'h204,0,32'h0,0);
    tbl[27] = V(0,1,1,0,0, 0,0,0,0,            0,32'h0,0,32'h0,1);
    tbl[28] = V(0,0,0,1,0, 1,32'h300,0,0,      0,32'h0,0,32'h0,1);
    tbl[29] = V(0,0,1,0,0, 0,0,0,0,            0,32'h0,0,32'h0,1);
    tbl[30] = V(0,0,0,0,1, 0,0,0,0,            1,32'h0,0,32'h0,0);
    tbl[31] = V(0,0,0,0,1, 0,0,0,0,            1,32'h4,1,32'h0,0);
    tbl[32] = V(1,0,0,0,0, 0,0,0,0,            1,32'h8,1,32'h4,0);
    tbl[33] = V(0,0,0,0,0, 0,0,0,0,            0,32'h0,0,32'h0,0);
    tbl[34] = V(0,0,0,0,1, 0,0,0,0,            1,32'h0,0,32'h0,0);
    tbl[35] = V(0,0,0,1,1, 0,0,0,0,            1,32'h4,1,32'h0,0);
    tbl[36] = V(1,0,0,1,0, 0,0,0,0,            0,32'h8,1,32'h0,0);
    tbl[37] = V(0,0,0,0,0, 0,0,0,0,            0,32'h0,0,32'h0,0);
    tbl[38] = V(0,0,0,0,1, 0,0,1,32'hFFFF_FFFC, 1,32'h0,0,32'h0,0);
    tbl[39] = V(0,0,0,0,1, 0,0,0,0,            1,32'hFFFF_FFFC,0,32'h0,0);
    tbl[40] = V(0,0,0,0,0, 0,0,0,0,            1,32'h0,1,32'hFFFF_FFFC,0);
    tbl[1].e_clr  = 1'b1;
    tbl[33].e_clr = 1'b1;
    tbl[37].e_clr = 1'b1;
    idle = V(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0);

    drive(tbl[0]);
    repeat (2) @(posedge clk);
    #1;

    for (int unsigned i = 0; i < 41; i++) begin
      drive(tbl[i]);
      check($sformatf("req[%0d]", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      check($sformatf("addr[%0d]", i), imem_addr, tbl[i].e_addr);
      check($sformatf("valid[%0d]", i), {31'd0, if_valid}, {31'd0, tbl[i].e_v});
      check($sformatf("halted[%0d]", i), {31'd0, halted}, {31'd0, tbl[i].e_halt});
      check($sformatf("afault[%0d]", i), {31'd0, align_fault}, 32'd0);
      if (tbl[i].e_v) begin
        check($sformatf("if_pc[%0d]", i), if_pc, tbl[i].e_pc);
        check($sformatf("if_inst[%0d]", i), if_inst, ~tbl[i].e_pc);
      end
      if (tbl[i].e_clr) begin
        check($sformatf("clr_pc[%0d]", i), if_pc, 32'd0);
        check($sformatf("clr_inst[%0d]", i), if_inst, 32'd0);
      end
      @(posedge clk);
      #1;
    end

    // Misaligned branch 0x102 alongside aligned jump 0x200, ack same cycle.
    drive(idle);
    imem_ack = 1'b1; br_taken = 1'b1; br_pc = 32'h102;
    jmp_taken = 1'b1; jmp_pc = 32'h200;
    check("al_addr0", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    drive(idle);
`ifdef PC_ALIGN_CHECK_EN
    check("al_fault1", {31'd0, align_fault}, 32'd1);
    check("al_addr1", imem_addr, 32'h4);
    check("al_valid1", {31'd0, if_valid}, 32'd1);
    check("al_pc1", if_pc, 32'h0);
`else
    check("al_fault1", {31'd0, align_fault}, 32'd0);
    check("al_addr1", imem_addr, 32'h100);
    check("al_valid1", {31'd0, if_valid}, 32'd0);
`endif
    @(posedge clk);
    #1;
    check("al_fault2", {31'd0, align_fault}, 32'd0);
`ifdef PC_ALIGN_CHECK_EN
    check("al_addr2", imem_addr, 32'h4);
`else
    check("al_addr2", imem_addr, 32'h100);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller. Owns the program counter and sequences it against a req/ack instruction memory.
- Arbitrates redirect sources: execute-stage branch over decode-stage jump.
- Presents one fetched instruction at a time to decode, with a one-entry skid register to absorb decode stalls.
- Handles halt/resume. Sits between the instruction memory port and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset and after halt.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- hlt  in  1  halt request (level)
- resume  in  1  leave HALT state (pulse)
- stall  in  1  decode cannot accept if_* this cycle
- br_taken  in  1  execute-stage redirect
- br_pc  in  32  execute-stage target
- jmp_taken  in  1  decode-stage redirect
- jmp_pc  in  32  decode-stage target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_rdata valid
- imem_rdata  in  32  fetched word
- if_valid  out  1  if_inst/if_pc valid
- if_pc  out  32  PC of if_inst
- if_inst  out  32  instruction to decode
- halted  out  1  in HALT state
- align_fault  out  1  misaligned redirect (PC_ALIGN_CHECK_EN only; else tied 0)

Behaviour:
- Reset (rst=1 at posedge, dominates all inputs):
  - state=IDLE, pc=RESET_PC, if_valid=0, if_pc=0, if_inst=0, skid empty, squash_pend=0, halted=0, align_fault=0.
  - imem_req is low during and after reset until REQ.
  - Reset mid-request abandons the request; memory must tolerate a dropped req.
- States: IDLE, REQ, SKID, HALT.
  - imem_req = (state==REQ).
  - imem_addr = pc, stable while req is high.
- IDLE: one cycle, then REQ. First req is asserted in the 2nd cycle after rst falls.
- REQ: req stays high until imem_ack; it is never withdrawn except by rst.
  - On ack, not squashed, (!if_valid || !stall): if_inst<=rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, stay REQ.
  - On ack, not squashed, if_valid && stall: skid<=rdata/pc, pc<=pc+4, go SKID.
  - Zero-wait memory (ack same cycle as req) gives 1 instruction/cycle.
- Consume: if_valid && !stall with no new load → if_valid<=0.
- Redirect: target = br_taken ? br_pc : jmp_pc. Branch wins when both are asserted.
  - Any redirect in IDLE/REQ/SKID: pc<=target; if_valid<=0; skid cleared.
  - Redirect in REQ without ack: set squash_pend; pc<=target. The next ack is discarded (no if_valid, pc unchanged), squash_pend clears, and req continues at the new pc.
  - Redirect in the same cycle as ack: data discarded, pc<=target; squash_pend is not set.
  - Redirect in SKID: go REQ.
- SKID: req low. When !stall: if_*<=skid, skid empty, go REQ.
- Halt: hlt=1 is sampled each cycle in IDLE/REQ/SKID.
  - In REQ without ack: wait for ack, discard it, then halt.
  - Otherwise halt next edge.
  - Entering HALT: pc<=RESET_PC, if_valid<=0, skid cleared, squash_pend<=0, halted<=1.
  - HALT ignores redirects and stall.
  - resume && !hlt → REQ, halted<=0. Resume while hlt=1 is ignored.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined:
  - A redirect whose target[1:0]!=0 is not taken. pc, if_valid and skid are unchanged, and the normal sequence continues.
  - align_fault pulses high for exactly one cycle, registered on the next edge.
  - A branch rejected for misalignment does not fall back to a simultaneous jump.
- Undefined: target[1:0] are forced to 0 before loading pc; align_fault is constant 0.

Test Plan:
- Reset then zero-wait memory (ack=req), stall=0 → imem_req first high 2nd cycle after reset; imem_addr 0,4,8,C on consecutive cycles; if_pc trails by one cycle.
- 2-cycle ack latency, stall=1 from first if_valid for 3 cycles → second word goes to SKID, imem_req low; on stall drop, if_pc 0 then 4 presented in order; no word lost or duplicated.
- br_taken=1, br_pc=0x100 and jmp_taken=1, jmp_pc=0x200 same cycle while req outstanding at 0x8 → ack for 0x8 discarded, next imem_addr=0x100, if_valid stays 0 until 0x100 returns.
- hlt=1 while req at 0x10 outstanding, ack 3 cycles later → halted=1 the cycle after ack, pc=RESET_PC, if_valid=0; resume with hlt=1 ignored; resume with hlt=0 → imem_addr=RESET_PC.
- rst pulse during outstanding req and during SKID → next cycle imem_req=0, if_valid=0, state IDLE, no stale if_inst.
- With PC_ALIGN_CHECK_EN, redirect to 0x102 → align_fault one-cycle pulse, sequence continues at pc+4; without the macro → fetch at 0x100.
